// File: rtl/ysyx_24090003_pkg.sv
// Shared decode types: RV32I opcodes, skid-buffer state, buffered entry and decoded-field bundle.
// Latency: n/a (types only). Backpressure: n/a.
package ysyx_24090003_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct;
        logic [31:0] imm;
        logic        illegal;
    } dec_fields_t;

endpackage

// File: rtl/ysyx_24090003_dec_ctrl_if.sv
// IFU->decode and decode->EXU valid/ready channels plus redirect flush.
// Latency: n/a (wiring). Backpressure: in_ready / out_ready.
interface ysyx_24090003_dec_ctrl_if;
    import ysyx_24090003_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct;
    logic [31:0]     out_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
               out_opcode, out_funct, out_imm, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
               out_opcode, out_funct, out_imm, out_illegal
    );

endinterface

// File: rtl/ysyx_24090003_dec_fields.sv
// Combinational RV32I field, immediate and illegal-opcode extraction from one instruction word.
// Latency: 0 cycles. Backpressure: none (pure logic).
module ysyx_24090003_dec_fields
    import ysyx_24090003_pkg::*;
(
    input  logic [31:0]  inst,
    output dec_fields_t  fields
);

    logic [6:0] opc;
    assign opc = inst[6:0];

    always_comb begin
        fields         = '0;
        fields.rs1     = inst[19:15];
        fields.rs2     = inst[24:20];
        fields.rd      = inst[11:7];
        fields.opcode  = opc;
        fields.funct   = inst[14:12];
        fields.illegal = 1'b0;
        unique case (opc)
            OP_LUI, OP_AUIPC:
                fields.imm = {inst[31:12], 12'b0};
            OP_JAL:
                fields.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            OP_BRANCH:
                fields.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_STORE:
                fields.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM, OP_SYSTEM:
                fields.imm = {{20{inst[31]}}, inst[31:20]};
            OP_OP:
                fields.imm = 32'b0;
            default: begin
                fields.imm     = 32'b0;
                fields.illegal = 1'b1;
            end
        endcase
        // Compressed / reserved encodings are already outside the base opcode list,
        // but the low-bit check is kept explicit for clarity.
        if (inst[1:0] != 2'b11) fields.illegal = 1'b1;
    end

endmodule

// File: rtl/ysyx_24090003_dec_ctrl.sv
// Decode-stage controller: two-entry skid buffer IFU->EXU with head-entry decode. Optional YSYX_24090003_DEC_PERF_EN adds perf counters.
// Latency: accepted at edge N, out_valid in cycle N+1; 1 inst/cycle streaming.
// Backpressure: in_ready low only when both entries full (registered); head held while out_valid && !out_ready; flush empties.
module ysyx_24090003_dec_ctrl
    import ysyx_24090003_pkg::*;
(
    input  logic                      cpu_clk,
    input  logic                      rst_n,
`ifdef YSYX_24090003_DEC_PERF_EN
    output logic [31:0]               perf_decoded,
    output logic [31:0]               perf_stall,
`endif
    ysyx_24090003_dec_ctrl_if.slave   dec
);

    dec_state_e  state;
    entry_t      head;
    entry_t      tail;
    entry_t      in_entry;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        push;
    logic        pop;
    dec_fields_t fields;

    assign in_entry = '{pc: dec.in_pc, inst: dec.in_inst};
    assign push     = dec.in_valid && in_ready_q && !dec.flush;
    assign pop      = out_valid_q && dec.out_ready;

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            head        <= '0;
            tail        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (dec.flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        head        <= in_entry;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        tail       <= in_entry;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop && !push) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (push && pop) begin
                        head <= in_entry;
                    end
                end
                TWO: begin
                    // Full: in_ready is low, so only a pop can move us.
                    if (pop) begin
                        head       <= tail;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    ysyx_24090003_dec_fields u_fields (
        .inst   (head.inst),
        .fields (fields)
    );

    assign dec.in_ready    = in_ready_q;
    assign dec.out_valid   = out_valid_q;
    assign dec.out_pc      = head.pc;
    assign dec.out_inst    = head.inst;
    assign dec.out_rs1     = fields.rs1;
    assign dec.out_rs2     = fields.rs2;
    assign dec.out_rd      = fields.rd;
    assign dec.out_opcode  = fields.opcode;
    assign dec.out_funct   = fields.funct;
    assign dec.out_imm     = fields.imm;
    // Stale head bytes (e.g. zeroed reset word) must not raise illegal while idle.
    assign dec.out_illegal = out_valid_q && fields.illegal;

`ifdef YSYX_24090003_DEC_PERF_EN
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) perf_decoded <= perf_decoded + 32'd1;
            if (out_valid_q && !dec.out_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24090003_dec_ctrl.sv
// Directed self-checking bench for the decode skid-buffer controller.
// Inputs change #1 after rising edges; outputs are sampled at the same point.
module tb_ysyx_24090003_dec_ctrl;
    import ysyx_24090003_pkg::*;

    logic cpu_clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

`ifdef YSYX_24090003_DEC_PERF_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_stall;
`endif

    ysyx_24090003_dec_ctrl_if dif ();

    ysyx_24090003_dec_ctrl dut (
        .cpu_clk      (cpu_clk),
        .rst_n        (rst_n),
`ifdef YSYX_24090003_DEC_PERF_EN
        .perf_decoded (perf_decoded),
        .perf_stall   (perf_stall),
`endif
        .dec          (dif)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    logic [31:0] t_inst [0:6] = '{32'h00500093, 32'h123450B7, 32'hFE20AE23, 32'hFE000CE3,
                                  32'h0000007F, 32'h00000012, 32'h002081B3};
    logic [31:0] t_imm  [0:6] = '{32'h00000005, 32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                  32'h00000000, 32'h00000000, 32'h00000000};
    logic        t_ill  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        dif.in_valid = v;
        dif.in_inst  = inst;
        dif.in_pc    = pc;
    endtask

    function automatic logic [31:0] addi_rd(input int i);
        logic [31:0] w;
        w = {i[11:0], 5'd0, 3'd0, i[4:0], 7'h13};
        return w;
    endfunction

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        dif.flush     = 1'b0;
        dif.out_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #12;
        chk("rst_in_ready",  {31'b0, dif.in_ready},    32'd1);
        chk("rst_out_valid", {31'b0, dif.out_valid},   32'd0);
        chk("rst_out_pc",    dif.out_pc,               32'd0);
        chk("rst_out_inst",  dif.out_inst,             32'd0);
        chk("rst_out_imm",   dif.out_imm,              32'd0);
        chk("rst_illegal",   {31'b0, dif.out_illegal}, 32'd0);
`ifdef YSYX_24090003_DEC_PERF_EN
        chk("rst_perf_dec",   perf_decoded, 32'd0);
        chk("rst_perf_stall", perf_stall,   32'd0);
`endif
        rst_n = 1'b1;
        cyc();

        // single push, then pop
        offer(1'b1, 32'h00500093, 32'h80000000);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        chk("p1_valid",   {31'b0, dif.out_valid},   32'd1);
        chk("p1_rd",      {27'b0, dif.out_rd},      32'd1);
        chk("p1_rs1",     {27'b0, dif.out_rs1},     32'd0);
        chk("p1_opcode",  {25'b0, dif.out_opcode},  32'h13);
        chk("p1_imm",     dif.out_imm,              32'd5);
        chk("p1_illegal", {31'b0, dif.out_illegal}, 32'd0);
        chk("p1_pc",      dif.out_pc,               32'h80000000);
        dif.out_ready = 1'b1;
        cyc();
        chk("p1_drained", {31'b0, dif.out_valid}, 32'd0);

        // full-rate stream of 8
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, addi_rd(i), 32'h80000100 + 32'(4 * i));
            cyc();
            chk("st_in_ready", {31'b0, dif.in_ready},  32'd1);
            chk("st_valid",    {31'b0, dif.out_valid}, 32'd1);
            chk("st_pc",       dif.out_pc,             32'h80000100 + 32'(4 * i));
            chk("st_rd",       {27'b0, dif.out_rd},    32'(i));
        end
        offer(1'b0, 32'h0, 32'h0);
        cyc();
        chk("st_drained", {31'b0, dif.out_valid}, 32'd0);

        // immediate / illegal table, streamed
        for (int i = 0; i < 7; i++) begin
            offer(1'b1, t_inst[i], 32'h80000200 + 32'(4 * i));
            cyc();
            chk("tb_inst",    dif.out_inst,                t_inst[i]);
            chk("tb_imm",     dif.out_imm,                 t_imm[i]);
            chk("tb_illegal", {31'b0, dif.out_illegal},    {31'b0, t_ill[i]});
        end
        offer(1'b0, 32'h0, 32'h0);
        cyc();

        // backpressure: 3 offered, 2 accepted, head frozen
        dif.out_ready = 1'b0;
        offer(1'b1, 32'h00A00093, 32'h80000300);
        cyc();
        offer(1'b1, 32'h00B00093, 32'h80000304);
        cyc();
        chk("bp_in_ready_two", {31'b0, dif.in_ready}, 32'd0);
        chk("bp_head_a",       dif.out_pc,            32'h80000300);
        offer(1'b1, 32'h00C00093, 32'h80000308);
        cyc();
        chk("bp_hold_ready", {31'b0, dif.in_ready}, 32'd0);
        chk("bp_hold_pc",    dif.out_pc,            32'h80000300);
        chk("bp_hold_inst",  dif.out_inst,          32'h00A00093);
        chk("bp_hold_imm",   dif.out_imm,           32'd10);
        dif.out_ready = 1'b1;
        cyc();
        chk("bp_head_b",  dif.out_pc,            32'h80000304);
        chk("bp_ready_b", {31'b0, dif.in_ready}, 32'd1);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        chk("bp_head_c", dif.out_pc,   32'h80000308);
        chk("bp_imm_c",  dif.out_imm,  32'd12);
        cyc();
        chk("bp_drained", {31'b0, dif.out_valid}, 32'd0);

        // push and pop together in ONE: head replaced by JAL
        dif.out_ready = 1'b0;
        offer(1'b1, 32'h00D00093, 32'h80000400);
        cyc();
        dif.out_ready = 1'b1;
        offer(1'b1, 32'hFE1FF0EF, 32'h80000404);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        dif.out_ready = 1'b0;
        chk("pp_valid",    {31'b0, dif.out_valid},  32'd1);
        chk("pp_in_ready", {31'b0, dif.in_ready},   32'd1);
        chk("pp_inst",     dif.out_inst,            32'hFE1FF0EF);
        chk("pp_pc",       dif.out_pc,              32'h80000404);
        chk("pp_jal_imm",  dif.out_imm,             32'hFFFFFFE0);
        chk("pp_opcode",   {25'b0, dif.out_opcode}, 32'h6F);
        // fill to TWO, then flush with an instruction on offer
        offer(1'b1, 32'h00E00093, 32'h80000408);
        cyc();
        chk("fl_in_ready_two", {31'b0, dif.in_ready}, 32'd0);
        offer(1'b1, 32'h00F00093, 32'h8000040C);
        dif.flush = 1'b1;
        cyc();
        dif.flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        chk("fl_valid",    {31'b0, dif.out_valid}, 32'd0);
        chk("fl_in_ready", {31'b0, dif.in_ready},  32'd1);
        cyc();
        chk("fl_not_taken", {31'b0, dif.out_valid}, 32'd0);
        // flush while EMPTY with an offer: still not accepted
        offer(1'b1, 32'h00F00093, 32'h8000040C);
        dif.flush = 1'b1;
        cyc();
        dif.flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        chk("fl_empty_offer", {31'b0, dif.out_valid}, 32'd0);

        // asynchronous reset mid-stream
        offer(1'b1, 32'h01000093, 32'h80000500);
        cyc();
        offer(1'b1, 32'h01100093, 32'h80000504);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #2;
        chk("ar_valid",    {31'b0, dif.out_valid}, 32'd0);
        chk("ar_in_ready", {31'b0, dif.in_ready},  32'd1);
        chk("ar_pc",       dif.out_pc,             32'd0);
        rst_n = 1'b1;
        cyc();

`ifdef YSYX_24090003_DEC_PERF_EN
        // counters were cleared by the reset above: 4 stall edges, then 3 pops
        dif.out_ready = 1'b0;
        offer(1'b1, 32'h01200093, 32'h80000600);
        cyc();
        offer(1'b1, 32'h01300093, 32'h80000604);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        cyc();
        chk("pf_stall_mid", perf_stall, 32'd4);
        dif.out_ready = 1'b1;
        cyc();
        offer(1'b1, 32'h0000007F, 32'h80000608);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        chk("pf_illegal", {31'b0, dif.out_illegal}, 32'd1);
        cyc();
        dif.out_ready = 1'b0;
        chk("pf_decoded", perf_decoded, 32'd3);
        chk("pf_stall",   perf_stall,   32'd4);
        dif.flush = 1'b1;
        cyc();
        dif.flush = 1'b0;
        chk("pf_flush_keep", perf_decoded, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
